mips_fetch_stage: RTL and testbench

MIPS_FETCH_STAGE -- requirements
Module: mips_fetch_stage

---
 rtl/mips_pkg.sv | 24 ++
 rtl/mips_if_id_reg.sv | 47 ++++
 rtl/mips_fetch_stage.sv | 161 ++++++++++++++++
 tb/tb_mips_fetch_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage: fetch FSM states, bubble
// encoding, default reset PC and small address helpers.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DISCARD = 2'd3
  } fetch_state_t;

  // sll $0,$0,0 -- decodes as opcode 0 / funct 0
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/mips_if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid flag, with
// bubble insertion taking priority over a stalled or fresh load.
module mips_if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        bubble,
  input  logic        load,
  input  logic [31:0] fetch_instr,
  input  logic [31:0] fetch_pc_plus4,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid
);

  logic [31:0] instr_r;
  logic [31:0] pc_plus4_r;
  logic        valid_r;

  // IF/ID contents: bubble beats load, load only when decode is not stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_r    <= NOP_INSTR;
      pc_plus4_r <= 32'h0000_0000;
      valid_r    <= 1'b0;
    end else if (bubble) begin
      instr_r    <= NOP_INSTR;
      pc_plus4_r <= pc_plus4_r;
      valid_r    <= 1'b0;
    end else if (load && !stall) begin
      instr_r    <= fetch_instr;
      pc_plus4_r <= fetch_pc_plus4;
      valid_r    <= 1'b1;
    end else begin
      instr_r    <= instr_r;
      pc_plus4_r <= pc_plus4_r;
      valid_r    <= valid_r;
    end
  end

  assign id_instr    = instr_r;
  assign id_pc_plus4 = pc_plus4_r;
  assign id_valid    = valid_r;

endmodule

// File: rtl/mips_fetch_stage.sv
// MIPS instruction fetch stage: PC register, single-outstanding fetch FSM
// (REQ/WAIT/HOLD/DISCARD) and the IF/ID register.
module mips_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter int          IMEM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic [5:0]  opcode,
  output logic [5:0]  funct
);

  fetch_state_t state_r;
  fetch_state_t next_state_s;
  logic [31:0]  pc_r;
  logic [31:0]  pc_next_s;
  logic [31:0]  hold_r;
  logic [31:0]  fetch_word_s;
  logic [31:0]  redirect_pc_s;
  logic         redirect_s;
  logic         capture_s;
  logic         load_s;
  logic         imem_req_s;

  // Timeout handling is reserved; the parameter carries no behaviour yet.
  if (IMEM_TIMEOUT != 0) begin : g_timeout_reserved
  end

  assign redirect_s    = jump | branch_taken;
  assign redirect_pc_s = word_align(jump ? jump_target : branch_target);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_REQ;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state, next-PC and IF/ID load decisions
  always_comb begin
    next_state_s = state_r;
    pc_next_s    = pc_r;
    capture_s    = 1'b0;
    load_s       = 1'b0;
    fetch_word_s = hold_r;
    case (state_r)
      ST_REQ: begin
        // A redirect here leaves the just-issued request in flight, so drain it.
        if (redirect_s) begin
          next_state_s = ST_DISCARD;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_s) begin
          next_state_s = imem_valid ? ST_REQ : ST_DISCARD;
        end else if (imem_valid && stall) begin
          next_state_s = ST_HOLD;
          capture_s    = 1'b1;
        end else if (imem_valid) begin
          next_state_s = ST_REQ;
          load_s       = 1'b1;
          fetch_word_s = imem_rdata;
          pc_next_s    = next_seq_pc(pc_r);
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (redirect_s) begin
          next_state_s = ST_REQ;
        end else if (!stall) begin
          next_state_s = ST_REQ;
          load_s       = 1'b1;
          fetch_word_s = hold_r;
          pc_next_s    = next_seq_pc(pc_r);
        end else begin
          next_state_s = ST_HOLD;
        end
      end
      ST_DISCARD: begin
        if (imem_valid) begin
          next_state_s = ST_REQ;
        end else begin
          next_state_s = ST_DISCARD;
        end
      end
      default: begin
        next_state_s = ST_REQ;
      end
    endcase
    if (redirect_s) begin
      pc_next_s = redirect_pc_s;
    end else begin
      pc_next_s = pc_next_s;
    end
  end

  // PC and hold register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r   <= RESET_PC;
      hold_r <= NOP_INSTR;
    end else begin
      pc_r <= pc_next_s;
      if (capture_s) begin
        hold_r <= imem_rdata;
      end else begin
        hold_r <= hold_r;
      end
    end
  end

  // Moore outputs; the request strobe is masked while reset is asserted
  always_comb begin
    imem_req_s = 1'b0;
    if ((state_r == ST_REQ) && rst_n) begin
      imem_req_s = 1'b1;
    end else begin
      imem_req_s = 1'b0;
    end
  end

  assign imem_req  = imem_req_s;
  assign imem_addr = pc_r;

  mips_if_id_reg u_if_id (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .bubble         (flush | redirect_s),
    .load           (load_s),
    .fetch_instr    (fetch_word_s),
    .fetch_pc_plus4 (next_seq_pc(pc_r)),
    .id_instr       (id_instr),
    .id_pc_plus4    (id_pc_plus4),
    .id_valid       (id_valid)
  );

  assign opcode = id_instr[31:26];
  assign funct  = id_instr[5:0];

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Self-checking bench for mips_fetch_stage: directed scenarios plus a random
// run against a transaction-level model (outstanding / dropped / held fetch).
module tb_mips_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall, flush, branch_taken, jump, imem_valid;
  logic [31:0] branch_target, jump_target, imem_rdata;
  logic        imem_req, id_valid;
  logic [31:0] imem_addr, id_instr, id_pc_plus4;
  logic [5:0]  opcode, funct;

  // second instance for the wrap-around reset PC
  logic        w_rst_n, w_iv, w_zero;
  logic [31:0] w_ird, w_zero32;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc4;
  logic [5:0]  w_opcode, w_funct;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // model state
  logic [31:0] m_pc, m_hword, e_instr, e_pc4;
  logic        m_issue, m_out, m_drop, m_held, e_valid;

  // memory responder state
  logic        rsp_pend;
  logic [31:0] rsp_addr;
  int          rsp_due;

  mips_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .id_instr(id_instr), .id_pc_plus4(id_pc_plus4), .id_valid(id_valid),
    .opcode(opcode), .funct(funct)
  );

  mips_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(w_rst_n), .stall(w_zero), .flush(w_zero),
    .branch_taken(w_zero), .branch_target(w_zero32),
    .jump(w_zero), .jump_target(w_zero32),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_rdata(w_ird), .imem_valid(w_iv),
    .id_instr(w_instr), .id_pc_plus4(w_pc4), .id_valid(w_valid),
    .opcode(w_opcode), .funct(w_funct)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[31:16] ^ a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0000_0000; m_issue = 1'b1; m_out = 1'b0; m_drop = 1'b0;
    m_held = 1'b0; m_hword = 32'h0;
    e_instr = 32'h0; e_pc4 = 32'h0; e_valid = 1'b0;
  endtask

  // One clock edge of the reference: what is in flight, what is held, what reaches decode.
  task automatic model_step();
    logic        redir, got, new_out, deliver;
    logic [31:0] tgt, dword, npc;
    redir   = jump | branch_taken;
    tgt     = jump ? jump_target : branch_target;
    tgt     = tgt & 32'hFFFF_FFFC;
    got     = imem_valid && m_out;
    new_out = (m_out && !got) || m_issue;
    deliver = 1'b0;
    dword   = 32'h0;
    if (redir) begin
      m_drop = new_out;
      m_held = 1'b0;
      npc    = tgt;
    end else begin
      if (got && !m_drop) begin
        if (stall) begin m_held = 1'b1; m_hword = imem_rdata; end
        else begin deliver = 1'b1; dword = imem_rdata; end
      end else if (m_held && !stall) begin
        deliver = 1'b1; dword = m_hword; m_held = 1'b0;
      end
      if (got) m_drop = 1'b0;
      npc = deliver ? m_pc + 32'd4 : m_pc;
    end
    if (redir || flush) begin
      e_instr = 32'h0; e_valid = 1'b0;
    end else if (deliver) begin
      e_instr = dword; e_pc4 = m_pc + 32'd4; e_valid = 1'b1;
    end
    m_pc    = npc;
    m_out   = new_out;
    m_issue = !new_out && !m_held;
  endtask

  task automatic compare_all();
    chk("imem_req",    {31'b0, imem_req}, {31'b0, m_issue && rst_n});
    chk("imem_addr",   imem_addr, m_pc);
    chk("id_instr",    id_instr, e_instr);
    chk("id_pc_plus4", id_pc_plus4, e_pc4);
    chk("id_valid",    {31'b0, id_valid}, {31'b0, e_valid});
    chk("opcode",      {26'b0, opcode}, {26'b0, e_instr[31:26]});
    chk("funct",       {26'b0, funct}, {26'b0, e_instr[5:0]});
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic clear_inputs();
    stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = 32'h0; jump_target = 32'h0; imem_valid = 1'b0; imem_rdata = 32'h0;
  endtask

  // Asynchronous reset pulse: outputs must clear before any clock edge.
  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    clear_inputs();
    rst_n    = 1'b1;
    rsp_pend = 1'b0;
    #1;
    compare_all();
  endtask

  initial begin
    rst_n = 1'b0; w_rst_n = 1'b0; w_iv = 1'b0; w_ird = 32'h0;
    w_zero = 1'b0; w_zero32 = 32'h0; rsp_pend = 1'b0; rsp_addr = 32'h0; rsp_due = 0;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);

    // wrap-around reset PC instance
    w_rst_n = 1'b1;
    #1;
    chk("wrap_first_req",  {31'b0, w_req}, 32'd1);
    chk("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_wait_req", {31'b0, w_req}, 32'd0);
    w_iv = 1'b1; w_ird = 32'h2402_0001;
    @(negedge clk);
    w_iv = 1'b0;
    chk("wrap_pc4",    w_pc4, 32'h0000_0000);
    chk("wrap_instr",  w_instr, 32'h2402_0001);
    chk("wrap_opcode", {26'b0, w_opcode}, 32'h0000_0009);
    chk("wrap_valid",  {31'b0, w_valid}, 32'd1);
    chk("wrap_addr",   w_addr, 32'h0000_0000);
    @(negedge clk);
    chk("wrap_wait2_req", {31'b0, w_req}, 32'd0);
    #2;
    w_rst_n = 1'b0;
    #1;
    chk("wrap_rst_addr",  w_addr, 32'hFFFF_FFFC);
    chk("wrap_rst_valid", {31'b0, w_valid}, 32'd0);
    chk("wrap_rst_instr", w_instr, 32'h0);
    chk("wrap_rst_pc4",   w_pc4, 32'h0);
    chk("wrap_rst_req",   {31'b0, w_req}, 32'd0);
    @(negedge clk);
    w_rst_n = 1'b1;
    #1;
    chk("wrap_refetch_req",  {31'b0, w_req}, 32'd1);
    chk("wrap_refetch_addr", w_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    w_iv = 1'b1; w_ird = 32'h0000_0025;
    @(negedge clk);
    w_iv = 1'b0;
    chk("wrap_funct", {26'b0, w_funct}, 32'h0000_0025);
    chk("wrap_pc4b",  w_pc4, 32'h0);

    // first fetch after reset, one-cycle memory latency
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compare_all();
    chk("lit_first_addr", imem_addr, 32'h0);
    tick();
    imem_valid = 1'b1; imem_rdata = 32'h8C08_0004;
    tick();
    imem_valid = 1'b0;
    chk("lit_first_instr",  id_instr, 32'h8C08_0004);
    chk("lit_first_opcode", {26'b0, opcode}, 32'h0000_0023);
    chk("lit_first_pc4",    id_pc_plus4, 32'h4);
    chk("lit_first_valid",  {31'b0, id_valid}, 32'd1);

    // stall for three cycles while the fetch at 8 returns
    tick();
    imem_valid = 1'b1; imem_rdata = 32'h2108_0001;
    tick();
    imem_valid = 1'b0;
    tick();
    stall = 1'b1; imem_valid = 1'b1; imem_rdata = 32'hAC09_0008;
    tick();
    imem_valid = 1'b0; imem_rdata = 32'h1357_9BDF;
    tick();
    tick();
    chk("lit_stall_instr", id_instr, 32'h2108_0001);
    chk("lit_stall_pc4",   id_pc_plus4, 32'h8);
    stall = 1'b0;
    tick();
    chk("lit_release_instr", id_instr, 32'hAC09_0008);
    chk("lit_release_addr",  imem_addr, 32'd12);

    // branch while waiting; the late response must be dropped
    tick();
    branch_taken = 1'b1; branch_target = 32'h0000_0040;
    tick();
    branch_taken = 1'b0; imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_valid = 1'b0;
    chk("lit_branch_valid", {31'b0, id_valid}, 32'd0);
    chk("lit_branch_addr",  imem_addr, 32'h0000_0040);

    // jump beats branch, coincident with a response
    tick();
    jump = 1'b1; jump_target = 32'h0000_0100;
    branch_taken = 1'b1; branch_target = 32'h0000_0040;
    imem_valid = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    clear_inputs();
    chk("lit_jump_addr", imem_addr, 32'h0000_0100);

    // flush with stall asserted
    tick();
    imem_valid = 1'b1; imem_rdata = 32'h0128_4020;
    tick();
    imem_valid = 1'b0;
    chk("lit_add_funct", {26'b0, funct}, 32'h0000_0020);
    stall = 1'b1; flush = 1'b1;
    tick();
    stall = 1'b0; flush = 1'b0;
    chk("lit_flush_instr", id_instr, 32'h0);
    chk("lit_flush_funct", {26'b0, funct}, 32'h0);
    chk("lit_flush_pc",    imem_addr, 32'h0000_0104);

    // reset in the middle of a wait, then randomized traffic
    pulse_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) pulse_reset();
      stall         = ($urandom_range(0, 9) < 3);
      flush         = ($urandom_range(0, 9) == 0);
      branch_taken  = ($urandom_range(0, 11) == 0);
      branch_target = $urandom;
      jump          = ($urandom_range(0, 19) == 0);
      jump_target   = $urandom;
      imem_valid    = 1'b0;
      imem_rdata    = $urandom;
      if (rsp_pend && cyc == rsp_due) begin
        imem_valid = 1'b1;
        imem_rdata = mem_word(rsp_addr);
        rsp_pend   = 1'b0;
      end else if (!rsp_pend && $urandom_range(0, 19) == 0) begin
        imem_valid = 1'b1;
      end
      if (imem_req) begin
        rsp_pend = 1'b1;
        rsp_addr = imem_addr;
        rsp_due  = cyc + int'($urandom_range(1, 3));
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
